mux_arb_nto1_reg: RTL

//  Parametrised N-to-1 datapath selector with a registered output and valid/ready handshake.

---
 rtl/mux_arb_nto1_reg.sv | 109 ++++++++++
 1 files changed

// File: rtl/mux_arb_nto1_reg.sv
// N-to-1 registered selector with valid/ready handshake.
// MODE 0 takes an explicit channel select; MODE 1 arbitrates round-robin among valid channels.
module mux_arb_nto1_reg #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int MODE   = 0,
  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        out_ch,
  input  logic                    out_ready,
  output logic                    sel_err
);

  localparam logic [SEL_W:0]   num_in_c  = (SEL_W+1)'(NUM_IN);
  localparam logic [SEL_W-1:0] last_ch_c = SEL_W'(NUM_IN - 1);

  logic [SEL_W-1:0] grant_s;
  logic [SEL_W-1:0] ptr_r;
  logic [SEL_W-1:0] ptr_next_s;
  logic             grant_valid_s;
  logic             sel_in_range_s;
  logic             load_s;
  logic [WIDTH-1:0] grant_data_s;

  // Grant selection: explicit select (guarded against out-of-range) or round-robin search from ptr_r.
  always_comb begin : grant_comb
    int idx;
    grant_s        = '0;
    grant_valid_s  = 1'b0;
    idx            = 0;
    sel_in_range_s = ({1'b0, sel} < num_in_c);
    if (MODE == 0) begin
      if (sel_in_range_s) begin
        grant_s       = sel;
        grant_valid_s = in_valid[sel];
      end else begin
        grant_s       = '0;
        grant_valid_s = 1'b0;
      end
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        idx = ((int'(ptr_r) + k) >= NUM_IN) ? (int'(ptr_r) + k - NUM_IN) : (int'(ptr_r) + k);
        if (!grant_valid_s && in_valid[idx]) begin
          grant_valid_s = 1'b1;
          grant_s       = SEL_W'(idx);
        end else begin
          grant_valid_s = grant_valid_s;
        end
      end
    end
    ptr_next_s = (grant_s == last_ch_c) ? '0 : (grant_s + SEL_W'(1));
  end

  assign load_s = !rst && (!out_valid || out_ready) && grant_valid_s;

  // Accept strobe and data mux for the granted channel.
  always_comb begin
    in_ready     = '0;
    grant_data_s = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_s == SEL_W'(i)) begin
        in_ready[i]  = load_s;
        grant_data_s = in_data[i*WIDTH +: WIDTH];
      end else begin
        in_ready[i]  = 1'b0;
      end
    end
  end

  // Output register, round-robin pointer and sticky select-error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      sel_err   <= 1'b0;
      ptr_r     <= '0;
    end else begin
      if (load_s) begin
        out_data  <= grant_data_s;
        out_ch    <= grant_s;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
      if (MODE == 0 && !sel_in_range_s) begin
        sel_err <= 1'b1;
      end else begin
        sel_err <= sel_err;
      end
      if (MODE != 0 && load_s) begin
        ptr_r <= ptr_next_s;
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

endmodule
